// File: rtl/i_mem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into words and
// writes them from BASE_ADDR upward while stalling the core.
module i_mem_loader #(
  parameter int unsigned          BUS_WIDTH   = 32,
  parameter int unsigned          DEPTH_WORDS = 1024,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR   = {BUS_WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [15:0]          load_len,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic [BUS_WIDTH-1:0] cpu_pc,
  output logic                 cpu_stall,
  output logic [BUS_WIDTH-1:0] i_mem_address,
  output logic                 i_mem_wr_en,
  output logic [BUS_WIDTH-1:0] i_mem_wr_data,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [15:0]          len_r;
  logic [15:0]          word_cnt_r;
  logic [1:0]           byte_cnt_r;
  logic [31:0]          word_r;
  logic                 load_err_r;
  logic                 req_ok_s;
  logic [BUS_WIDTH-1:0] wr_addr_s;

  // Zero length and lengths beyond the memory depth are rejected.
  assign req_ok_s  = (load_len != 16'd0) && (32'(load_len) <= DEPTH_WORDS);
  assign wr_addr_s = BASE_ADDR + BUS_WIDTH'({word_cnt_r, 2'b00});
  assign load_err  = load_err_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and output decode; the core keeps the memory address only in IDLE.
  always_comb begin
    state_s       = state_r;
    busy          = 1'b1;
    cpu_stall     = 1'b1;
    byte_ready    = 1'b0;
    i_mem_wr_en   = 1'b0;
    i_mem_wr_data = {BUS_WIDTH{1'b0}};
    i_mem_address = wr_addr_s;
    load_done     = 1'b0;
    case (state_r)
      IDLE: begin
        busy          = 1'b0;
        cpu_stall     = 1'b0;
        i_mem_address = cpu_pc;
        if (load_start && req_ok_s) begin
          state_s = RECV;
        end else begin
          state_s = IDLE;
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_cnt_r == 2'd3)) begin
          state_s = WRITE;
        end else begin
          state_s = RECV;
        end
      end
      WRITE: begin
        i_mem_wr_en   = 1'b1;
        i_mem_wr_data = BUS_WIDTH'(word_r);
        if ((word_cnt_r + 16'd1) == len_r) begin
          state_s = DONE;
        end else begin
          state_s = RECV;
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_s   = IDLE;
      end
      default: begin
        busy          = 1'b0;
        cpu_stall     = 1'b0;
        i_mem_address = cpu_pc;
        state_s       = IDLE;
      end
    endcase
  end

  // Request latching, byte-lane assembly and word counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r      <= 16'd0;
      word_cnt_r <= 16'd0;
      byte_cnt_r <= 2'd0;
      word_r     <= 32'd0;
      load_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_start) begin
            if (req_ok_s) begin
              load_err_r <= 1'b0;
              len_r      <= load_len;
              word_cnt_r <= 16'd0;
              byte_cnt_r <= 2'd0;
              word_r     <= 32'd0;
            end else begin
              load_err_r <= 1'b1;
            end
          end
        end
        RECV: begin
          if (byte_valid) begin
            word_r[{byte_cnt_r, 3'b000} +: 8] <= byte_in;
            byte_cnt_r                        <= byte_cnt_r + 2'd1;
          end
        end
        WRITE: begin
          word_cnt_r <= word_cnt_r + 16'd1;
          word_r     <= 32'd0;
        end
        default: begin
          len_r <= len_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_loader.sv
// Directed bench for i_mem_loader: a cycle table for a one-word load and rejected
// requests, plus hand-written multi-word, gap, reset and ignored-start sequences.
module tb_i_mem_loader;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        load_start = 1'b0;
  logic [15:0] load_len   = 16'd0;
  logic [7:0]  byte_in    = 8'd0;
  logic        byte_valid = 1'b0;
  logic [31:0] cpu_pc     = 32'h0000_0100;
  logic        byte_ready, cpu_stall, i_mem_wr_en, busy, load_done, load_err;
  logic [31:0] i_mem_address, i_mem_wr_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  src [0:15];
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  typedef struct {
    logic        ls;
    logic [15:0] len;
    logic [7:0]  b;
    logic        bv;
    logic        busy, stall, ready, we, chk_addr;
    logic [31:0] addr, data;
    logic        done, err;
  } vec_t;

  vec_t vt [13];

  i_mem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .i_mem_address(i_mem_address),
    .i_mem_wr_en(i_mem_wr_en), .i_mem_wr_data(i_mem_wr_data), .busy(busy),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ls, input logic [15:0] len, input logic [7:0] b,
                              input logic bv, input logic bsy, input logic stl, input logic rdy,
                              input logic we, input logic ca, input logic [31:0] addr,
                              input logic [31:0] data, input logic dn, input logic er);
    vec_t v;
    v.ls = ls; v.len = len; v.b = b; v.bv = bv;
    v.busy = bsy; v.stall = stl; v.ready = rdy; v.we = we; v.chk_addr = ca;
    v.addr = addr; v.data = data; v.done = dn; v.err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_stall"}, 32'(cpu_stall),   32'd0);
    chk({tag, "_ready"}, 32'(byte_ready),  32'd0);
    chk({tag, "_we"},    32'(i_mem_wr_en), 32'd0);
    chk({tag, "_wdata"}, i_mem_wr_data,    32'd0);
    chk({tag, "_done"},  32'(load_done),   32'd0);
    chk({tag, "_err"},   32'(load_err),    32'd0);
    chk({tag, "_addr"},  i_mem_address,    cpu_pc);
  endtask

  // Cycle 0 is the first RECV cycle; gap = idle cycles after each accepted byte;
  // pulse_at >= 0 fires a stray load_start (len 1) in that cycle.
  task automatic run_load(input int len, input int gap, input int pulse_at, output int done_cyc);
    int cyc;
    int bi;
    int gapcnt;
    wa.delete();
    wd.delete();
    done_cyc = -1;
    cyc = 0;
    bi = 0;
    gapcnt = 0;
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 16'(len);
    byte_valid = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    load_len   = 16'hFFFF;
    while (cyc < 2000 && done_cyc < 0) begin
      byte_valid = (gapcnt == 0) && (bi < 4 * len);
      byte_in    = (bi < 16) ? src[bi] : 8'h00;
      load_start = (cyc == pulse_at);
      load_len   = (cyc == pulse_at) ? 16'h0001 : 16'hFFFF;
      #1;
      if (byte_ready && byte_valid) begin
        bi++;
        gapcnt = gap;
      end else if (gapcnt > 0) begin
        gapcnt--;
      end
      if (i_mem_wr_en) begin
        wa.push_back(i_mem_address);
        wd.push_back(i_mem_wr_data);
      end
      if (load_done) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    #1;
    chk("post_done_stall", 32'(cpu_stall), 32'd0);
    chk("post_done_busy",  32'(busy),      32'd0);
    chk("post_done_addr",  i_mem_address,  cpu_pc);
  endtask

  task automatic check_writes(input int len, input string tag);
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'(len));
    for (int k = 0; k < len && k < wa.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), wa[k], 32'(4 * k));
      chk($sformatf("%s_data%0d", tag, k), wd[k],
          {src[4*k+3], src[4*k+2], src[4*k+1], src[4*k]});
    end
  endtask

  initial begin
    int d;
    vt[0]  = mk(1'b0, 16'd0,    8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0,  1'b0, 1'b0);
    vt[1]  = mk(1'b1, 16'd1,    8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0,  1'b0, 1'b0);
    vt[2]  = mk(1'b0, 16'd0,    8'h13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0);
    vt[3]  = mk(1'b0, 16'd0,    8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0);
    vt[4]  = mk(1'b0, 16'd0,    8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0);
    vt[5]  = mk(1'b0, 16'd0,    8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0);
    vt[6]  = mk(1'b0, 16'd0,    8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,   32'h13, 1'b0, 1'b0);
    vt[7]  = mk(1'b0, 16'd0,    8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0);
    vt[8]  = mk(1'b0, 16'd0,    8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0,  1'b0, 1'b0);
    vt[9]  = mk(1'b1, 16'd0,    8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0,  1'b0, 1'b0);
    vt[10] = mk(1'b0, 16'd0,    8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0,  1'b0, 1'b1);
    vt[11] = mk(1'b1, 16'd1025, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0,  1'b0, 1'b1);
    vt[12] = mk(1'b0, 16'd0,    8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0,  1'b0, 1'b1);
    for (int i = 0; i < 16; i++) src[i] = 8'(i * 29 + 7);

    #2 rst = 1'b0;
    #2 chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      load_start = vt[i].ls;
      load_len   = vt[i].len;
      byte_in    = vt[i].b;
      byte_valid = vt[i].bv;
      #1;
      chk($sformatf("v%0d_busy", i),  32'(busy),        32'(vt[i].busy));
      chk($sformatf("v%0d_stall", i), 32'(cpu_stall),   32'(vt[i].stall));
      chk($sformatf("v%0d_ready", i), 32'(byte_ready),  32'(vt[i].ready));
      chk($sformatf("v%0d_we", i),    32'(i_mem_wr_en), 32'(vt[i].we));
      chk($sformatf("v%0d_wdata", i), i_mem_wr_data,    vt[i].data);
      chk($sformatf("v%0d_done", i),  32'(load_done),   32'(vt[i].done));
      chk($sformatf("v%0d_err", i),   32'(load_err),    32'(vt[i].err));
      if (vt[i].chk_addr) chk($sformatf("v%0d_addr", i), i_mem_address, vt[i].addr);
    end
    load_start = 1'b0;
    byte_valid = 1'b0;

    cpu_pc = 32'h0000_2000;
    run_load(3, 0, -1, d);
    chk("len3_done_cycle", 32'(d), 32'd15);
    check_writes(3, "len3");
    chk("len3_err_cleared", 32'(load_err), 32'd0);

    run_load(2, 3, -1, d);
    chk("gap3_done_cycle", 32'(d), 32'd30);
    check_writes(2, "gap3");

    run_load(3, 0, 5, d);
    chk("stray_start_done_cycle", 32'(d), 32'd15);
    check_writes(3, "stray_start");

    @(negedge clk);
    load_start = 1'b1;
    load_len   = 16'd2;
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b1;
    byte_in    = 8'hAA;
    @(negedge clk);
    byte_in    = 8'hBB;
    @(negedge clk);
    byte_valid = 1'b0;
    #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("midrst_hold%0d_we", i), 32'(i_mem_wr_en), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    src[0] = 8'h13; src[1] = 8'h00; src[2] = 8'h00; src[3] = 8'h00;
    run_load(1, 0, -1, d);
    chk("after_rst_done_cycle", 32'(d), 32'd5);
    check_writes(1, "after_rst");

    @(negedge clk);
    load_start = 1'b1;
    load_len   = 16'd0;
    @(negedge clk);
    load_start = 1'b0;
    #1;
    chk("err_before_rst", 32'(load_err), 32'd1);
    rst = 1'b0;
    #1;
    chk("err_cleared_by_rst", 32'(load_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_mem_loader.md
I_MEM_LOADER -- requirements
Module: i_mem_loader

Interface
REQ-001 Parameter BUS_WIDTH, default 32, shall set the address and data width of the memory-side port.
REQ-002 Parameter DEPTH_WORDS, default 1024, shall set the maximum loadable program length in words.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, shall set the byte address of the first loaded word.
REQ-004 clk  in  1  shall be the single clock; all state shall change on its rising edge.
REQ-005 rst  in  1  shall be the reset: asynchronous, active-low.
REQ-006 load_start  in  1  shall be a one-cycle request to begin a program load.
REQ-007 load_len  in  16  shall be the number of words to load, sampled when load_start is accepted.
REQ-008 byte_in  in  8  shall be the program byte stream.
REQ-009 byte_valid  in  1  shall mark byte_in as valid.
REQ-010 byte_ready  out  1  shall indicate the block accepts a byte this cycle.
REQ-011 cpu_pc  in  BUS_WIDTH  shall be the fetch address from the core.
REQ-012 cpu_stall  out  1  shall hold the core while the loader owns the memory.
REQ-013 i_mem_address  out  BUS_WIDTH  shall drive the instruction memory address.
REQ-014 i_mem_wr_en  out  1  shall drive the instruction memory write enable.
REQ-015 i_mem_wr_data  out  BUS_WIDTH  shall drive the instruction memory write data.
REQ-016 busy  out  1  shall be high in every state other than IDLE.
REQ-017 load_done  out  1  shall pulse for one cycle when a load completes.
REQ-018 load_err  out  1  shall flag a rejected load request.

Function
REQ-019 The FSM shall have four states: IDLE, RECV, WRITE and DONE.
REQ-020 IDLE behaviour shall be:
- i_mem_address = cpu_pc (combinational)
- i_mem_wr_en = 0, byte_ready = 0, cpu_stall = 0
REQ-021 When load_start=1 in IDLE, the block shall reject the request if load_len==0 or load_len>DEPTH_WORDS:
- set load_err=1
- remain in IDLE
REQ-022 When load_start=1 in IDLE with a valid load_len, the block shall:
- clear load_err
- latch load_len
- clear word_cnt and byte_cnt
- enter RECV on the next edge
REQ-023 load_err shall remain set until the next accepted or rejected load_start.
REQ-024 In RECV, byte_ready shall be 1, and each cycle with byte_valid=1 shall store byte_in in lane byte_cnt of the word (little-endian: lane 0 = bits 7:0) and increment byte_cnt.
REQ-025 Acceptance of the 4th byte (byte_cnt==3) shall move the FSM to WRITE and wrap byte_cnt to 0.
REQ-026 WRITE shall last exactly one cycle with the following outputs:
- i_mem_wr_en = 1
- i_mem_address = BASE_ADDR + 4*word_cnt
- i_mem_wr_data = the assembled word
- byte_ready = 0
REQ-027 At the end of WRITE, word_cnt shall increment, and the FSM shall go to DONE if the incremented count equals the latched length, otherwise to RECV.
REQ-028 DONE shall last one cycle with load_done=1, then the FSM shall return to IDLE.
REQ-029 cpu_stall shall be 1 in RECV, WRITE and DONE, and the core shall see cpu_pc-driven addressing again in the cycle after DONE.
REQ-030 Outside WRITE, i_mem_wr_en shall be 0 and i_mem_wr_data shall be 0.
REQ-031 load_start shall be ignored while busy=1, and load_len changes after acceptance shall have no effect.
REQ-032 Stalled byte_valid (low) in RECV shall hold all state indefinitely, with no timeout.
REQ-033 Minimum per-word latency shall be 5 cycles (4 accepted bytes + 1 write).
REQ-034 Address arithmetic shall be modulo 2^BUS_WIDTH.

Reset
REQ-035 Asserting rst=0 at any time, including mid-load, shall asynchronously:
- force the FSM to IDLE
- clear word_cnt, byte_cnt and the partial word, which is discarded
- drive busy=0, cpu_stall=0, byte_ready=0, i_mem_wr_en=0, i_mem_wr_data=0, load_done=0, load_err=0
REQ-036 After rst returns to 1, operation shall resume on the first rising edge.

Verification
REQ-037 Bench shall cover: load_len=1 with bytes 0x13,0x00,0x00,0x00 -> a single WRITE cycle with address 0x0, data 0x00000013, wr_en=1, then load_done pulse, cpu_stall low one cycle later.
REQ-038 Bench shall cover: load_len=3 with 12 back-to-back bytes -> writes to 0x0, 0x4, 0x8; total 15 cycles from the first RECV cycle to DONE.
REQ-039 Bench shall cover: load_len=0, then load_len=DEPTH_WORDS+1 -> load_err=1 each time, busy stays 0, and no write occurs.
REQ-040 Bench shall cover: byte_valid gaps of 3 cycles between bytes -> identical written data, and byte_cnt holds during gaps.
REQ-041 Bench shall cover: rst=0 after 2 bytes of word 1 -> no write issued, all outputs at reset values immediately; a new load afterwards starts at BASE_ADDR.
REQ-042 Bench shall cover: load_start pulsed during RECV -> ignored, and the latched length completes unchanged.
